// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks.
//   PAR_NONE/PAR_EVEN/PAR_ODD : parity-mode encodings for the PARITY parameter
//   uart_state_t              : transmitter FSM states
//   frame_bits()              : total bits per frame (start + data + parity + stop)
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   clr  : restart the bit period (counter back to 0)
//   en   : count while high
//   tick : high on the last cycle of each bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with ready/send handshake.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   send  : frame request, accepted when ready is high
//   data  : payload, latched on the accept edge
//   txd   : serial line, idle high
//   ready : a new frame can be accepted this cycle
//   done  : one-cycle pulse in the final cycle of the last stop bit
//
// state     | meaning
// ----------+-------------------------------------------
// ST_IDLE   | line idle high, waiting for send
// ST_START  | driving the start bit (0)
// ST_DATA   | shifting out DATA_W payload bits
// ST_PARITY | driving the parity bit (PARITY != 0 only)
// ST_STOP   | driving STOP_BITS stop bits (1)
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [DATA_W-1:0] data,
  output logic              txd,
  output logic              ready,
  output logic              done
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  uart_state_t       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;
  logic              tick;
  logic              accept;
  logic              last_stop;

  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state_q != ST_IDLE),
    .tick(tick)
  );

  // The last stop-bit cycle doubles as an accept window so frames can
  // run back to back without an idle bit in between.
  assign last_stop = (state_q == ST_STOP) && (bit_cnt_q == LAST_STOP) && tick;
  assign ready     = (state_q == ST_IDLE) || last_stop;
  assign done      = last_stop;
  assign accept    = send && ready;
  assign txd       = txd_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    txd_d     = txd_q;
    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          state_d = ST_START;
          shreg_d = data;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          par_d     = (^shreg_q) ^ (PARITY == PAR_ODD);
          txd_d     = out_bit(shreg_q);
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shreg_d   = shift(shreg_q);
            txd_d     = out_bit(shift(shreg_q));
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
          txd_d     = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            if (accept) begin
              state_d = ST_START;
              shreg_d = data;
              txd_d   = 1'b0;
            end else begin
              state_d = ST_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations side by side, a frame-level
// reference model compared every cycle, plus directed literal checks.
module tb_uart_tx_param;

  localparam int C = 4;
  localparam int DW_A   [4] = '{8, 7, 7, 8};
  localparam int PAR_A  [4] = '{0, 1, 2, 0};
  localparam int STOP_A [4] = '{1, 1, 1, 2};
  localparam int LSB_A  [4] = '{1, 1, 1, 0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] send;
  logic [8:0] data [4];
  logic [3:0] txd, ready, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1), .LSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst_n), .send(send[0]), .data(data[0][7:0]),
    .txd(txd[0]), .ready(ready[0]), .done(done[0]));
  uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1), .LSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst_n), .send(send[1]), .data(data[1][6:0]),
    .txd(txd[1]), .ready(ready[1]), .done(done[1]));
  uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1), .LSB_FIRST(1)) u2 (
    .clk(clk), .rst(rst_n), .send(send[2]), .data(data[2][6:0]),
    .txd(txd[2]), .ready(ready[2]), .done(done[2]));
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(2), .LSB_FIRST(0)) u3 (
    .clk(clk), .rst(rst_n), .send(send[3]), .data(data[3][7:0]),
    .txd(txd[3]), .ready(ready[3]), .done(done[3]));

  task automatic check(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int flen(input int i);
    return 1 + DW_A[i] + ((PAR_A[i] != 0) ? 1 : 0) + STOP_A[i];
  endfunction

  // Bit k of the result is the line level during bit period k of the frame.
  function automatic logic [15:0] build(input int i, input logic [8:0] d);
    logic [15:0] f;
    logic        p;
    int          k;
    f    = '1;
    f[0] = 1'b0;
    p    = 1'b0;
    for (int j = 0; j < DW_A[i]; j++) begin
      f[1+j] = (LSB_A[i] != 0) ? d[j] : d[DW_A[i]-1-j];
      p      = p ^ d[j];
    end
    k = 1 + DW_A[i];
    if (PAR_A[i] != 0) f[k] = (PAR_A[i] == 1) ? p : ~p;
    return f;
  endfunction

  bit          m_busy [4] = '{0, 0, 0, 0};
  int          m_n    [4] = '{0, 0, 0, 0};
  logic [15:0] m_fr   [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_busy[i] = 0;
        m_n[i]    = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        bit last;
        last = m_busy[i] && (m_n[i] == flen(i) * C - 1);
        if (send[i] && (!m_busy[i] || last)) begin
          m_fr[i]   = build(i, data[i]);
          m_busy[i] = 1;
          m_n[i]    = 0;
        end else if (m_busy[i]) begin
          if (last) m_busy[i] = 0;
          else      m_n[i]    = m_n[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      logic et, er, ed;
      et = m_busy[i] ? m_fr[i][m_n[i] / C] : 1'b1;
      ed = m_busy[i] && (m_n[i] == flen(i) * C - 1);
      er = !m_busy[i] || ed;
      check("model_txd",   i, {15'b0, txd[i]},   {15'b0, et});
      check("model_ready", i, {15'b0, ready[i]}, {15'b0, er});
      check("model_done",  i, {15'b0, done[i]},  {15'b0, ed});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xmit(input int i, input logic [8:0] d, input int nb,
                      output logic [15:0] bits, output int dc);
    bits = '0;
    dc   = -1;
    @(negedge clk);
    data[i] = d;
    send[i] = 1'b1;
    @(negedge clk);
    send[i] = 1'b0;
    data[i] = ~d;
    for (int c = 0; c < nb * C + 4; c++) begin
      if ((c % C) == 2 && (c / C) < nb) bits[c / C] = txd[i];
      if (done[i] && dc < 0) dc = c;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] bits;
    logic [15:0] b2;
    int          dc, d1, d2, ndone;
    logic        gap;

    send  = '0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_txd",   0, {15'b0, txd[0]},   16'd1);
    check("rst_ready", 0, {15'b0, ready[0]}, 16'd1);
    check("rst_done",  0, {15'b0, done[0]},  16'd0);
    #2 rst_n = 1'b1;

    xmit(0, 9'h0A5, 10, bits, dc);
    check("a5_bits", 0, bits, 16'h034A);
    check("a5_done", 0, 16'(dc), 16'd39);

    xmit(1, 9'h003, 10, bits, dc);
    check("even_bits", 1, bits, 16'h0206);
    check("even_done", 1, 16'(dc), 16'd39);

    xmit(2, 9'h003, 10, bits, dc);
    check("odd_bits", 2, bits, 16'h0306);
    check("odd_done", 2, 16'(dc), 16'd39);

    xmit(3, 9'h080, 11, bits, dc);
    check("msb_bits", 3, bits, 16'h0602);
    check("msb_done", 3, 16'(dc), 16'd43);

    // back-to-back frames with send held high
    d1 = -1; d2 = -1; b2 = '0; gap = 1'b1;
    @(negedge clk);
    data[0] = 9'h055;
    send[0] = 1'b1;
    for (int c = 0; c < 86; c++) begin
      @(negedge clk);
      if (c == 0)  data[0] = 9'h0AA;
      if (c == 40) send[0] = 1'b0;
      if (done[0]) begin
        if (d1 < 0)      d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (c == 40) gap = txd[0];
      if (c >= 40 && ((c - 40) % C) == 2 && ((c - 40) / C) < 10) b2[(c - 40) / C] = txd[0];
    end
    check("b2b_done1", 0, 16'(d1), 16'd39);
    check("b2b_done2", 0, 16'(d2), 16'd79);
    check("b2b_nogap", 0, {15'b0, gap}, 16'd0);
    check("b2b_bits",  0, b2, 16'h0354);

    // send while busy is ignored
    ndone = 0;
    @(negedge clk);
    data[0] = 9'h0F0;
    send[0] = 1'b1;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (c == 0)  begin send[0] = 1'b0; data[0] = 9'h000; end
      if (c == 12) begin send[0] = 1'b1; data[0] = 9'h012; end
      if (c == 13) send[0] = 1'b0;
      if (done[0]) ndone++;
    end
    check("busy_ndone", 0, 16'(ndone), 16'd1);
    check("busy_ready", 0, {15'b0, ready[0]}, 16'd1);
    check("busy_txd",   0, {15'b0, txd[0]},   16'd1);

    // reset in the middle of the data bits
    @(negedge clk);
    data[0] = 9'h099;
    send[0] = 1'b1;
    @(negedge clk);
    send[0] = 1'b0;
    repeat (15) @(negedge clk);
    check("pre_rst_txd", 0, {15'b0, txd[0]}, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_txd",   0, {15'b0, txd[0]},   16'd1);
    check("mid_rst_ready", 0, {15'b0, ready[0]}, 16'd1);
    check("mid_rst_done",  0, {15'b0, done[0]},  16'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    xmit(0, 9'h03C, 10, bits, dc);
    check("post_rst_bits", 0, bits, 16'h0278);
    check("post_rst_done", 0, 16'(dc), 16'd39);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter; next generation of the fixed 8-bit serialiser. Adds configurable data width, baud divider, parity, stop-bit count and bit order, and emits a standard idle-high frame. It sits between a byte-producing client (ready/send handshake) and the `txd` pin, and supports back-to-back frames with no idle gap.

## Interface
- `DATA_W`, 8: data bits per frame; legal 5..9.
- `CLKS_PER_BIT`, 16: clock cycles per bit; legal ≥ 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `LSB_FIRST`, 1: 1 = bit 0 first, 0 = bit DATA_W-1 first.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `send`  in  1  request; a frame is accepted on an edge where `send`=1 and `ready`=1.
- `data`  in  DATA_W  payload; sampled only on the accept edge.
- `txd`  out  1  serial line; idle high.
- `ready`  out  1  high when a new frame can be accepted.
- `done`  out  1  single-cycle pulse in the final cycle of the last stop bit.

## Operation
- Reset values: `txd`=1, `ready`=1, `done`=0, state IDLE, counters 0.
- Frame: start (0), DATA_W data bits, optional parity bit, STOP_BITS stop bits (1). F = 1 + DATA_W + (PARITY≠0) + STOP_BITS bits.
- Parity: even → XOR of data bits; odd → inverted XOR. Computed from the latched word.
- States: IDLE → START → DATA → PARITY (only if PARITY≠0) → STOP → IDLE, or START directly on back-to-back accept.
- Bit counter: 0..DATA_W-1 in DATA; 0..STOP_BITS-1 in STOP. Baud counter: 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and is cleared on accept.
- `data` is copied to a shift register on accept. Later changes to `data` do not affect the frame.
- `send` while `ready`=0 is ignored; there is no queue and no error flag.
- Reset asserted mid-frame: `txd` goes to 1 asynchronously, the frame is dropped, and `ready` returns to 1.

## Timing
- Accept on edge E0: from E0, `txd`=0 (start bit) and `ready`=0, both registered.
- Each bit holds for exactly CLKS_PER_BIT cycles. Bit k occupies the cycles from E0+k·CLKS_PER_BIT.
- In the final cycle of the last stop bit (starting at edge E0+F·CLKS_PER_BIT−1): `ready`=1 and `done`=1.
- If `send`=1 in that cycle, the next start bit begins at E0+F·CLKS_PER_BIT with zero gap. Otherwise `txd` stays 1 in IDLE.
- Throughput: one frame per F·CLKS_PER_BIT cycles.
- Latency from accept to the first `txd` change: 0 cycles after the accept edge.

## Structure
- Package `uart_pkg`: parity-mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`), the state enum typedef, and a frame-length function F(DATA_W, PARITY, STOP_BITS).
- Sub-module `uart_baud_gen`:
  - Parameter CLKS_PER_BIT; inputs `clk`, `rst`, `clr`, `en`; output `tick`.
  - `tick` = 1 on the last cycle of each bit.
  - Reused by the future receiver.
- Top level holds the FSM, shift register, bit counter, parity register and handshake.

## Test plan
- Defaults but CLKS_PER_BIT=4; send 0xA5 → `txd` = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles; `done` pulses at cycle 39 after accept.
- DATA_W=7, PARITY=1, send 0x03 → parity bit 0. Same with PARITY=2 → parity bit 1. Frame = 10 bits.
- STOP_BITS=2, LSB_FIRST=0, send 0x80 → start 0, then 1,0,0,0,0,0,0,0, then two stop bits of 1; 11·CLKS_PER_BIT cycles total.
- `send` held high with 0x55 then 0xAA → second start bit immediately follows the first frame's stop bit; no idle cycle; two `done` pulses exactly F·CLKS_PER_BIT apart.
- Pulse `send` with 0x12 while `ready`=0, mid-frame → ignored; the current frame is unchanged and no extra frame follows.
- Assert `rst` during the data bits → `txd`=1 and `ready`=1 immediately. After release, a new send of 0x3C transmits correctly from its start bit.
